seek_controller: RTL and testbench

SEEK_CONTROLLER -- requirements
Module: seek_controller

---
 rtl/seek_controller.sv | 205 ++++++++++++++++++++
 tb/tb_seek_controller.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seek_controller.sv
// Floppy-style head seek controller: steps a stepper-driven head to a target track or recalibrates to track 0.
// Latency: invalid seek -> done 1 cycle after accept; motion -> DIR_SETUP + n*STEP_PERIOD + SETTLE + 1 cycles.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while busy and nothing is queued.
module seek_controller #(
    parameter int DIR_SETUP   = 4,
    parameter int PULSE_W     = 4,
    parameter int STEP_PERIOD = 32,
    parameter int SETTLE      = 64,
    parameter int MAX_TRACK   = 79,
    parameter int RECAL_LIMIT = 85
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [6:0] cmd_track,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       homed,
    output logic [6:0] cur_track,
    input  logic       tr0,
    output logic       step,
    output logic       dir,
    output logic       en
);

    // One shared down-counter times every state; 16 bits covers any sane period.
    localparam int CNT_W  = 16;
    localparam int RCNT_W = $clog2(RECAL_LIMIT + 1);

    // Counter reload values: a state loaded with N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(DIR_SETUP - 1);
    localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0]  LOW_LD    = CNT_W'(STEP_PERIOD - PULSE_W - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [RCNT_W-1:0] RECAL_MAX = RCNT_W'(RECAL_LIMIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STEP_HI,
        ST_STEP_LO,
        ST_SETTLE,
        ST_FIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              recal_q, recal_d;
    logic [6:0]        target_q, target_d;
    logic [6:0]        cur_track_q, cur_track_d;
    logic              dir_q, dir_d;
    logic              error_q, error_d;
    logic              homed_q, homed_d;
    logic [RCNT_W-1:0] rsteps_q, rsteps_d;

    logic cnt_zero;
    logic track_oor;

    assign cnt_zero  = (cnt_q == '0);
    assign track_oor = (int'({25'd0, cmd_track}) > MAX_TRACK);

    // Next-state, counter and head-position bookkeeping.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        recal_d     = recal_q;
        target_d    = target_q;
        cur_track_d = cur_track_q;
        dir_d       = dir_q;
        error_d     = error_q;
        homed_d     = homed_q;
        rsteps_d    = rsteps_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    recal_d  = cmd_recal;
                    target_d = cmd_track;
                    error_d  = 1'b0;
                    rsteps_d = '0;
                    if (cmd_recal) begin
                        dir_d   = 1'b1;
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end else begin
                        dir_d = (cmd_track < cur_track_q);
                        if (track_oor || !homed_q) begin
                            // Unknown position or illegal target: report without moving.
                            error_d = 1'b1;
                            state_d = ST_FIN;
                        end else if (cmd_track == cur_track_q) begin
                            state_d = ST_SETTLE;
                            cnt_d   = SETTLE_LD;
                        end else begin
                            state_d = ST_SETUP;
                            cnt_d   = SETUP_LD;
                        end
                    end
                end
            end

            // End of SETUP or of a step low phase is the single decision
            // point for whether another step pulse is issued.
            ST_SETUP, ST_STEP_LO: begin
                if (cnt_zero) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                    if (recal_q) begin
                        if (tr0) begin
                            cur_track_d = '0;
                            homed_d     = 1'b1;
                        end else if (rsteps_q == RECAL_MAX) begin
                            error_d = 1'b1;
                            homed_d = 1'b0;
                        end else begin
                            state_d  = ST_STEP_HI;
                            cnt_d    = PULSE_LD;
                            rsteps_d = rsteps_q + RCNT_W'(1);
                            // Position is meaningless until tr0 is found; just keep it from wrapping.
                            cur_track_d = (cur_track_q == '0) ? '0 : cur_track_q - 7'd1;
                        end
                    end else if (cur_track_q != target_q) begin
                        if (dir_q && tr0) begin
                            // Head already at the stop: do not drive into it.
                            cur_track_d = '0;
                            error_d     = 1'b1;
                        end else begin
                            state_d     = ST_STEP_HI;
                            cnt_d       = PULSE_LD;
                            cur_track_d = dir_q ? cur_track_q - 7'd1 : cur_track_q + 7'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_STEP_HI: begin
                if (cnt_zero) begin
                    state_d = ST_STEP_LO;
                    cnt_d   = LOW_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_d = ST_FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            recal_q     <= 1'b0;
            target_q    <= '0;
            cur_track_q <= '0;
            dir_q       <= 1'b0;
            error_q     <= 1'b0;
            homed_q     <= 1'b0;
            rsteps_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            recal_q     <= recal_d;
            target_q    <= target_d;
            cur_track_q <= cur_track_d;
            dir_q       <= dir_d;
            error_q     <= error_d;
            homed_q     <= homed_d;
            rsteps_q    <= rsteps_d;
        end
    end

    // Outputs are forced low while rst is high so the coil driver releases
    // in the reset cycle itself, even mid-pulse.
    assign busy      = (state_q != ST_IDLE) && !rst;
    assign en        = busy;
    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign step      = (state_q == ST_STEP_HI) && !rst;
    assign done      = (state_q == ST_FIN) && !rst;
    assign dir       = dir_q && !rst;
    assign error     = error_q && !rst;
    assign homed     = homed_q && !rst;
    assign cur_track = rst ? 7'd0 : cur_track_q;

endmodule

// File: tb/tb_seek_controller.sv
// Bench for seek_controller: directed scenarios plus random seeks against a track/timing model.
// Latency is predicted from the step-timing rules with plain arithmetic.
// Inputs driven just after the falling edge; outputs read there too.
module tb_seek_controller;

    localparam int DS   = 4;
    localparam int PW   = 2;
    localparam int SP   = 8;
    localparam int ST   = 5;
    localparam int MAXT = 79;
    localparam int RL   = 85;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_recal = 1'b0;
    logic [6:0] cmd_track = 7'd0;
    logic       tr0 = 1'b0;
    logic       cmd_ready, busy, done, error, homed, step, dir, en;
    logic [6:0] cur_track;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model of the head
    int cur_m = 0;
    bit homed_m = 0;

    // Monitor records
    int   rise_cyc[$];
    logic rise_dir[$];
    int   rise_trk[$];
    int   last_dir_chg = 0;
    int   setup_viol = 0;
    int   en_bad = 0;
    int   dir_flip = 0;
    logic step_prev = 1'b0;
    logic dir_prev = 1'b0;
    logic busy_prev = 1'b0;

    seek_controller #(
        .DIR_SETUP(DS), .PULSE_W(PW), .STEP_PERIOD(SP), .SETTLE(ST),
        .MAX_TRACK(MAXT), .RECAL_LIMIT(RL)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_recal(cmd_recal), .cmd_track(cmd_track), .busy(busy), .done(done),
        .error(error), .homed(homed), .cur_track(cur_track), .tr0(tr0),
        .step(step), .dir(dir), .en(en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Records every step rising edge and watches dir/en behaviour.
    always @(negedge clk) begin
        if (dir !== dir_prev) begin
            last_dir_chg = cyc;
            if (busy && busy_prev) dir_flip++;
        end
        if (step === 1'b1 && step_prev !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_dir.push_back(dir);
            rise_trk.push_back(int'(cur_track));
            if (cyc - last_dir_chg < DS) setup_viol++;
        end
        if (en !== busy) en_bad++;
        step_prev = step;
        dir_prev  = dir;
        busy_prev = busy;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issues one command from IDLE and waits (bounded) for done; optionally raises tr0
    // once tr0_after step pulses of this command have been seen.
    task automatic run_cmd(input logic recal, input logic [6:0] trk, input int tr0_after,
                           input int budget, output int acc, output int done_at);
        int b0;
        bit got;
        b0 = rise_cyc.size();
        got = 0;
        done_at = -1;
        cmd_recal = recal;
        cmd_track = trk;
        cmd_valid = 1'b1;
        acc = cyc;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (tr0_after >= 0 && rise_cyc.size() - b0 >= tr0_after) tr0 = 1'b1;
            if (done === 1'b1) begin
                got = 1;
                done_at = cyc;
            end else begin
                tick();
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL cmd_timeout: no done within %0d cycles (recal=%0d track=%0d)", budget, recal, trk);
        end
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1;
        cmd_track = 7'd5;
        tick();
        tick();
        checks++;
        if ({step, dir, en, busy, done, error, homed, cmd_ready} !== 8'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000000", {step, dir, en, busy, done, error, homed, cmd_ready});
        end
        checks++;
        if (cur_track !== 7'd0) begin
            errors++;
            $display("FAIL reset_track: got %0d want 0", cur_track);
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: cmd_ready=%b busy=%b want 1 0", cmd_ready, busy);
        end
    endtask

    task automatic test_unhomed_seek();
        int acc, d, b;
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd5, -1, 20, acc, d);
        checks++;
        if (d - acc !== 1) begin
            errors++;
            $display("FAIL unhomed_latency: got %0d want 1", d - acc);
        end
        checks++;
        if (error !== 1'b1 || homed !== 1'b0) begin
            errors++;
            $display("FAIL unhomed_status: error=%b homed=%b want 1 0", error, homed);
        end
        checks++;
        if (rise_cyc.size() - b !== 0) begin
            errors++;
            $display("FAIL unhomed_pulses: got %0d want 0", rise_cyc.size() - b);
        end
        tick();
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL error_hold: error=%b done=%b busy=%b want 1 0 0", error, done, busy);
        end
    endtask

    task automatic test_recal_home();
        int acc, d, b, n, bad, last;
        b = rise_cyc.size();
        run_cmd(1'b1, 7'd0, 3, 500, acc, d);
        n = rise_cyc.size() - b;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL recal_pulses: got %0d want 3", n);
        end
        bad = 0;
        for (int i = 0; i < n; i++) if (rise_dir[b + i] !== 1'b1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL recal_dir: %0d pulses with dir!=1, want 0", bad);
        end
        checks++;
        if (homed !== 1'b1 || cur_track !== 7'd0 || error !== 1'b0) begin
            errors++;
            $display("FAIL recal_status: homed=%b track=%0d error=%b want 1 0 0", homed, cur_track, error);
        end
        last = (n > 0) ? rise_cyc[b + n - 1] : -1000;
        checks++;
        if (d !== last + SP + ST) begin
            errors++;
            $display("FAIL recal_done_time: got %0d want %0d", d, last + SP + ST);
        end
        tr0 = 1'b0;
        tick();
        homed_m = 1;
        cur_m = 0;
    endtask

    task automatic test_seek_timing();
        int acc, d, b, n;
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd3, -1, 200, acc, d);
        n = rise_cyc.size() - b;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL seek3_pulses: got %0d want 3", n);
        end
        for (int i = 0; i < n && i < 3; i++) begin
            checks++;
            if (rise_cyc[b + i] - acc !== 1 + DS + i * SP || rise_dir[b + i] !== 1'b0 || rise_trk[b + i] !== i + 1) begin
                errors++;
                $display("FAIL seek3_rise%0d: at=%0d dir=%b trk=%0d want at=%0d dir=0 trk=%0d",
                         i, rise_cyc[b + i] - acc, rise_dir[b + i], rise_trk[b + i], 1 + DS + i * SP, i + 1);
            end
        end
        checks++;
        if (d - acc !== 1 + DS + 3 * SP + ST) begin
            errors++;
            $display("FAIL seek3_done_time: got %0d want %0d", d - acc, 1 + DS + 3 * SP + ST);
        end
        checks++;
        if (cur_track !== 7'd3 || error !== 1'b0) begin
            errors++;
            $display("FAIL seek3_status: track=%0d error=%b want 3 0", cur_track, error);
        end
        tick();
        cur_m = 3;
    endtask

    task automatic test_equal_and_range();
        int acc, d, b;
        run_cmd(1'b0, 7'd10, -1, 200, acc, d);
        checks++;
        if (cur_track !== 7'd10) begin
            errors++;
            $display("FAIL seek10_track: got %0d want 10", cur_track);
        end
        tick();
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd10, -1, 50, acc, d);
        checks++;
        if (rise_cyc.size() - b !== 0 || d - acc !== 1 + ST || error !== 1'b0) begin
            errors++;
            $display("FAIL same_track: pulses=%0d latency=%0d error=%b want 0 %0d 0",
                     rise_cyc.size() - b, d - acc, error, 1 + ST);
        end
        tick();
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd80, -1, 20, acc, d);
        checks++;
        if (rise_cyc.size() - b !== 0 || d - acc !== 1 || error !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range: pulses=%0d latency=%0d error=%b want 0 1 1", rise_cyc.size() - b, d - acc, error);
        end
        checks++;
        if (cur_track !== 7'd10 || homed !== 1'b1) begin
            errors++;
            $display("FAIL out_of_range_pos: track=%0d homed=%b want 10 1", cur_track, homed);
        end
        tick();
        cur_m = 10;
    endtask

    task automatic test_outward_tr0();
        int acc, d, b, n;
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd3, -1, 200, acc, d);
        checks++;
        if (rise_cyc.size() - b !== 7 || cur_track !== 7'd3 || rise_dir[b] !== 1'b1) begin
            errors++;
            $display("FAIL outward7: pulses=%0d track=%0d dir=%b want 7 3 1", rise_cyc.size() - b, cur_track, rise_dir[b]);
        end
        tick();
        b = rise_cyc.size();
        run_cmd(1'b0, 7'd0, 1, 200, acc, d);
        n = rise_cyc.size() - b;
        checks++;
        if (n !== 1) begin
            errors++;
            $display("FAIL tr0_stop_pulses: got %0d want 1", n);
        end
        checks++;
        if (cur_track !== 7'd0 || error !== 1'b1) begin
            errors++;
            $display("FAIL tr0_stop_status: track=%0d error=%b want 0 1", cur_track, error);
        end
        checks++;
        if (n > 0 && d !== rise_cyc[b] + SP + ST) begin
            errors++;
            $display("FAIL tr0_stop_done_time: got %0d want %0d", d, rise_cyc[b] + SP + ST);
        end
        tr0 = 1'b0;
        tick();
        cur_m = 0;
    endtask

    task automatic test_random();
        int acc, d, b, n, t, exp_done, bad, got_n;
        logic exp_err, exp_dir;
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 4))
                0:       t = 80 + int'($urandom_range(0, 47));
                1:       t = cur_m;
                default: t = int'($urandom_range(0, 79));
            endcase
            n = 0;
            exp_err = 1'b0;
            exp_dir = (t < cur_m);
            if (t > MAXT || !homed_m) begin
                exp_err = 1'b1;
                exp_done = 1;
            end else begin
                n = (t > cur_m) ? t - cur_m : cur_m - t;
                exp_done = (n == 0) ? 1 + ST : 1 + DS + n * SP + ST;
            end
            b = rise_cyc.size();
            run_cmd(1'b0, 7'(t), -1, exp_done + 50, acc, d);
            got_n = rise_cyc.size() - b;
            checks++;
            if (got_n !== n || d - acc !== exp_done || error !== exp_err) begin
                errors++;
                $display("FAIL rand_seek%0d to %0d: pulses=%0d latency=%0d error=%b want %0d %0d %b",
                         k, t, got_n, d - acc, error, n, exp_done, exp_err);
            end
            bad = 0;
            for (int i = 0; i < got_n && i < n; i++) begin
                if (rise_dir[b + i] !== exp_dir || rise_cyc[b + i] - acc !== 1 + DS + i * SP ||
                    rise_trk[b + i] !== (exp_dir ? cur_m - i - 1 : cur_m + i + 1)) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_pulses%0d to %0d: %0d bad pulses want 0", k, t, bad);
            end
            if (!exp_err) cur_m = t;
            checks++;
            if (cur_track !== 7'(cur_m)) begin
                errors++;
                $display("FAIL rand_track%0d: got %0d want %0d", k, cur_track, cur_m);
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        int t2, n, acc, bad, bad2, exp_done;
        bit got;
        t2 = (cur_m == 20) ? 30 : 20;
        n = (t2 > cur_m) ? t2 - cur_m : cur_m - t2;
        exp_done = 1 + DS + n * SP + ST;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_idle: got %b want 1", cmd_ready);
        end
        cmd_recal = 1'b0;
        cmd_track = 7'(t2);
        cmd_valid = 1'b1;
        acc = cyc;
        tick();
        cmd_track = 7'd1;
        bad = 0;
        got = 0;
        for (int i = 0; i < exp_done + 50 && !got; i++) begin
            if (done === 1'b1) begin
                got = 1;
            end else begin
                if (cmd_ready !== 1'b0 || busy !== 1'b1) bad++;
                tick();
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (!got || cyc - acc !== exp_done) begin
            errors++;
            $display("FAIL busy_seek_done: got=%0d latency=%0d want 1 %0d", got, cyc - acc, exp_done);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_ready: %0d cycles with cmd_ready high or busy low, want 0", bad);
        end
        tick();
        cur_m = t2;
        checks++;
        if (cur_track !== 7'(t2)) begin
            errors++;
            $display("FAIL busy_track: got %0d want %0d", cur_track, t2);
        end
        bad2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy !== 1'b0) bad2++;
            tick();
        end
        checks++;
        if (bad2 !== 0) begin
            errors++;
            $display("FAIL no_queue: busy for %0d cycles after completion, want 0", bad2);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int t, acc, d, b, n, bad, exp_done;
        bit got;
        t = (cur_m < 40) ? cur_m + 5 : cur_m - 5;
        cmd_recal = 1'b0;
        cmd_track = 7'(t);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (step === 1'b1) got = 1;
            else tick();
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL midpulse_reach: step never rose, want a pulse");
        end
        rst = 1'b1;
        #1;
        checks++;
        if (step !== 1'b0 || en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_same_cycle: step=%b en=%b busy=%b want 0 0 0", step, en, busy);
        end
        tick();
        checks++;
        if (step !== 1'b0 || homed !== 1'b0 || cur_track !== 7'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_midpulse: step=%b homed=%b track=%0d done=%b want 0 0 0 0", step, homed, cur_track, done);
        end
        rst = 1'b0;
        homed_m = 0;
        cur_m = 0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_abort: %0d cycles with done/busy after reset, want 0", bad);
        end
        tr0 = 1'b0;
        exp_done = 1 + DS + RL * SP + ST;
        b = rise_cyc.size();
        run_cmd(1'b1, 7'd0, -1, exp_done + 50, acc, d);
        n = rise_cyc.size() - b;
        checks++;
        if (n !== RL || d - acc !== exp_done) begin
            errors++;
            $display("FAIL recal_limit: pulses=%0d latency=%0d want %0d %0d", n, d - acc, RL, exp_done);
        end
        checks++;
        if (error !== 1'b1 || homed !== 1'b0) begin
            errors++;
            $display("FAIL recal_limit_status: error=%b homed=%b want 1 0", error, homed);
        end
        tick();
    endtask

    task automatic test_invariants();
        checks++;
        if (en_bad !== 0) begin
            errors++;
            $display("FAIL en_eq_busy: %0d cycles en!=busy, want 0", en_bad);
        end
        checks++;
        if (dir_flip !== 0) begin
            errors++;
            $display("FAIL dir_stable: %0d dir changes mid-command, want 0", dir_flip);
        end
        checks++;
        if (setup_viol !== 0) begin
            errors++;
            $display("FAIL dir_setup: %0d step edges with dir setup < %0d, want 0", setup_viol, DS);
        end
    endtask

    initial begin
        test_reset();
        test_unhomed_seek();
        test_recal_home();
        test_seek_timing();
        test_equal_and_range();
        test_outward_tr0();
        test_random();
        test_busy_ignore();
        test_reset_mid_pulse();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
